// File: rtl/video_pkg.sv
// ============================================================================
// Module      : video_pkg
// Description : Shared video RAM widths, default bitmap geometry and types.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package video_pkg;

    localparam int VRAM_AW = 15;
    localparam int VRAM_DW = 8;

    typedef logic [VRAM_AW-1:0] vaddr_t;
    typedef logic [VRAM_DW-1:0] vbyte_t;

    localparam vaddr_t c_base_addr_default      = 15'h4000;
    localparam int     c_bytes_per_line_default = 40;

endpackage

`default_nettype wire

// File: rtl/video_fetch_if.sv
// ============================================================================
// Module      : video_fetch_if
// Description : Read-only video RAM port (port 2) between fetcher and RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface video_fetch_if;
    import video_pkg::*;

    logic   ram_en;
    vaddr_t ram_addr;
    vbyte_t ram_data;

    modport master (output ram_en, output ram_addr, input ram_data);
    modport slave  (input ram_en, input ram_addr, output ram_data);
endinterface

`default_nettype wire

// File: rtl/video_fetch_byte_fifo.sv
// ============================================================================
// Module      : byte_fifo
// Description : DEPTH x 8 synchronous show-ahead FIFO; flush beats push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_fifo
    import video_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   push,
    input  wire vbyte_t                 din,
    input  wire logic                   pop,
    input  wire logic                   flush,
    output vbyte_t                      dout,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty
);

    localparam int AW = $clog2(DEPTH);

    vbyte_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = push && (r_count != (AW+1)'(DEPTH));
    assign w_do_pop  = pop && (r_count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + AW'(1);
            if (w_do_pop)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    // Storage carries no reset; validity is tracked entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr] <= din;
    end

    assign dout  = r_mem[r_rd];
    assign count = r_count;
    assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/video_fetch.sv
// ============================================================================
// Module      : video_fetch
// Description : 1bpp bitmap line fetcher and MSB-first pixel serialiser.
//               Optional VIDEO_FETCH_DOUBLE_SCAN_EN repeats each bitmap line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_fetch
    import video_pkg::*;
#(
    parameter vaddr_t BASE_ADDR      = c_base_addr_default,
    parameter int     BYTES_PER_LINE = c_bytes_per_line_default,
    parameter int     FIFO_DEPTH     = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    input  wire logic     frame_start,
    input  wire logic     line_start,
    input  wire logic     pix_en,
    video_fetch_if.master ram,
    output logic          pixel,
    output logic          underrun
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    vaddr_t          r_line_base;
    logic            r_first_line;
    logic            r_active;
    logic [7:0]      r_issued;
    logic [7:0]      r_popped;
    logic            r_ram_en;
    vaddr_t          r_ram_addr;
    logic            r_rvalid;
    logic            r_rdisc;
    logic [7:0]      r_sh;
    logic [2:0]      r_bitcnt;
    logic            r_pixel;
    logic            r_underrun;

    logic            w_first_eff;
    vaddr_t          w_base_eff;
    logic            w_advance;
    vaddr_t          w_next_base;
    logic            w_inflight;
    logic            w_fetch;
    logic            w_push;
    logic            w_pop;
    vbyte_t          w_fifo_dout;
    logic [CW-1:0]   w_fifo_count;
    logic            w_fifo_empty;

`ifdef VIDEO_FETCH_DOUBLE_SCAN_EN
    logic            r_toggle;
    logic            w_toggle_eff;
`endif

    // frame_start is folded in first so a coincident line_start is the first line.
    always_comb begin
        w_first_eff = frame_start ? 1'b1 : r_first_line;
        w_base_eff  = frame_start ? BASE_ADDR : r_line_base;
`ifdef VIDEO_FETCH_DOUBLE_SCAN_EN
        w_toggle_eff = frame_start ? 1'b0 : r_toggle;
        w_advance    = !w_first_eff && w_toggle_eff;
`else
        w_advance    = !w_first_eff;
`endif
        w_next_base = w_advance ? (w_base_eff + vaddr_t'(BYTES_PER_LINE)) : w_base_eff;
    end

    // A read tagged for discard no longer occupies FIFO space, so it does not stall the new line.
    assign w_inflight = r_ram_en || (r_rvalid && !r_rdisc);
    assign w_fetch    = r_active && (r_issued < 8'(BYTES_PER_LINE)) && !w_inflight
                        && (w_fifo_count < CW'(FIFO_DEPTH)) && !line_start;
    assign w_push     = r_rvalid && !r_rdisc && r_active;
    assign w_pop      = pix_en && !line_start && (r_bitcnt == 3'd0) && !w_fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line_base  <= BASE_ADDR;
            r_first_line <= 1'b1;
            r_active     <= 1'b0;
            r_issued     <= '0;
            r_ram_en     <= 1'b0;
            r_ram_addr   <= '0;
            r_rvalid     <= 1'b0;
            r_rdisc      <= 1'b0;
        end else begin
            r_ram_en <= w_fetch;
            r_rvalid <= r_ram_en;
            r_rdisc  <= r_ram_en && line_start;
            if (w_fetch) begin
                r_ram_addr <= r_line_base + vaddr_t'(r_issued);
                r_issued   <= r_issued + 8'd1;
            end
            if (line_start) begin
                r_line_base  <= w_next_base;
                r_first_line <= 1'b0;
                r_active     <= 1'b1;
                r_issued     <= '0;
            end else if (frame_start) begin
                r_line_base  <= BASE_ADDR;
                r_first_line <= 1'b1;
            end
        end
    end

`ifdef VIDEO_FETCH_DOUBLE_SCAN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_toggle <= 1'b0;
        end else if (line_start) begin
            r_toggle <= w_first_eff ? w_toggle_eff : !w_toggle_eff;
        end else if (frame_start) begin
            r_toggle <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh       <= '0;
            r_bitcnt   <= '0;
            r_popped   <= '0;
            r_pixel    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (frame_start) r_underrun <= 1'b0;
            if (line_start) begin
                r_sh     <= '0;
                r_bitcnt <= '0;
                r_popped <= '0;
                if (pix_en) r_pixel <= 1'b0;
            end else if (pix_en) begin
                if (r_bitcnt != 3'd0) begin
                    r_pixel  <= r_sh[7];
                    r_sh     <= {r_sh[6:0], 1'b0};
                    r_bitcnt <= r_bitcnt - 3'd1;
                end else if (!w_fifo_empty) begin
                    r_pixel  <= w_fifo_dout[7];
                    r_sh     <= {w_fifo_dout[6:0], 1'b0};
                    r_bitcnt <= 3'd7;
                    r_popped <= r_popped + 8'd1;
                end else begin
                    r_pixel <= 1'b0;
                    if (r_active && (r_popped < 8'(BYTES_PER_LINE))) r_underrun <= 1'b1;
                end
            end
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (ram.ram_data),
        .pop   (w_pop),
        .flush (line_start),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .empty (w_fifo_empty)
    );

    assign ram.ram_en   = r_ram_en;
    assign ram.ram_addr = r_ram_addr;
    assign pixel        = r_pixel;
    assign underrun     = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_video_fetch.sv
// ============================================================================
// Module      : tb_video_fetch
// Description : Self-checking bench for video_fetch (two instances: 4000h, 7FF0h).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_fetch;
    import video_pkg::*;

    localparam int c_bpl = 40;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_start = 1'b0;
    logic line_start = 1'b0;
    logic pix_en = 1'b0;
    logic pixel, underrun, pixel_w, underrun_w;

    video_fetch_if ram();
    video_fetch_if ram_w();

    video_fetch #(.BASE_ADDR(15'h4000), .BYTES_PER_LINE(c_bpl), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
        .pix_en(pix_en), .ram(ram), .pixel(pixel), .underrun(underrun));

    video_fetch #(.BASE_ADDR(15'h7FF0), .BYTES_PER_LINE(c_bpl), .FIFO_DEPTH(4)) dut_w (
        .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
        .pix_en(pix_en), .ram(ram_w), .pixel(pixel_w), .underrun(underrun_w));

    always #5 clk = ~clk;

    logic [7:0] mem [32768];

    always @(posedge clk) begin
        if (ram.ram_en)   ram.ram_data   <= mem[ram.ram_addr];
        if (ram_w.ram_en) ram_w.ram_data <= mem[ram_w.ram_addr];
    end

    vaddr_t q_a[$];
    vaddr_t q_w[$];
    always @(negedge clk) begin
        if (ram.ram_en)   q_a.push_back(ram.ram_addr);
        if (ram_w.ram_en) q_w.push_back(ram_w.ram_addr);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge: pulses line_start, then streams npix pixels from E3+1.
    task automatic run_line(input logic fs, input vaddr_t a, input vaddr_t aw, input int npix,
                            input logic keep_pix, input logic full, output logic [7:0] first8);
        int bad, bad_w, nb, nbw;
        vaddr_t ea, ew;
        logic [7:0] b, bw;
        frame_start = fs;
        line_start  = 1'b1;
        pix_en      = keep_pix;
        @(negedge clk);
        frame_start = 1'b0;
        line_start  = 1'b0;
        pix_en      = 1'b0;
        if (keep_pix) check("flush_pixel", pixel, 1'b0);
        q_a.delete();
        q_w.delete();
        @(negedge clk);
        check("fetch_latency", ram.ram_en, 1'b1);
        check("first_addr", ram.ram_addr, a);
        check("first_addr_w", ram_w.ram_addr, aw);
        @(negedge clk);
        @(negedge clk);
        pix_en = 1'b1;
        bad = 0; bad_w = 0; first8 = '0;
        for (int i = 0; i < npix; i++) begin
            @(negedge clk);
            ea = a + vaddr_t'(i / 8);
            ew = aw + vaddr_t'(i / 8);
            b  = mem[ea];
            bw = mem[ew];
            if (pixel !== b[7 - (i % 8)]) bad++;
            if (pixel_w !== bw[7 - (i % 8)]) bad_w++;
            if (i < 8) first8 = {first8[6:0], pixel};
        end
        check("pixel_stream", bad, 0);
        check("pixel_stream_w", bad_w, 0);
        if (full) begin
            @(negedge clk);
            check("border_pixel", pixel, 1'b0);
            pix_en = 1'b0;
            check("no_underrun", underrun, 1'b0);
            check("no_underrun_w", underrun_w, 1'b0);
            repeat (4) @(negedge clk);
            check("read_count", q_a.size(), c_bpl);
            check("read_count_w", q_w.size(), c_bpl);
            nb = 0; nbw = 0;
            foreach (q_a[j]) if (q_a[j] !== a + vaddr_t'(j)) nb++;
            foreach (q_w[j]) if (q_w[j] !== aw + vaddr_t'(j)) nbw++;
            check("read_addrs", nb, 0);
            check("read_addrs_w", nbw, 0);
        end
    endtask

    task automatic wait_ram_en(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (ram.ram_en) seen = 1'b1;
            else @(negedge clk);
        end
        check(name, seen, 1'b1);
    endtask

    typedef struct {
        logic       fs;
        vaddr_t     a;
        vaddr_t     aw;
        logic [7:0] first;
    } line_vec_t;

    line_vec_t vecs [3];
    vaddr_t    l4_a, l4_w, l5_a, l5_w;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] f8;
        int ones, reads;

        for (int a = 0; a < 32768; a++) mem[a] = 8'(a) ^ 8'h3C;
        mem[15'h4000] = 8'hA5;

        vecs[0] = '{1'b1, 15'h4000, 15'h7FF0, 8'hA5};
`ifdef VIDEO_FETCH_DOUBLE_SCAN_EN
        vecs[1] = '{1'b0, 15'h4000, 15'h7FF0, 8'hA5};
        vecs[2] = '{1'b0, 15'h4028, 15'h0018, 8'h14};
        l4_a = 15'h4028; l4_w = 15'h0018;
        l5_a = 15'h4050; l5_w = 15'h0040;
`else
        vecs[1] = '{1'b0, 15'h4028, 15'h0018, 8'h14};
        vecs[2] = '{1'b0, 15'h4050, 15'h0040, 8'h6C};
        l4_a = 15'h4078; l4_w = 15'h0068;
        l5_a = 15'h40A0; l5_w = 15'h0090;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ram_en", ram.ram_en, 1'b0);
        check("rst_ram_addr", ram.ram_addr, 15'h0);
        check("rst_pixel", pixel, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_ram_en", ram.ram_en, 1'b0);

        // Underrun: pixel demanded right after line_start, sticky until frame_start
        frame_start = 1'b1; line_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; line_start = 1'b0; pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        check("underrun_pixel", pixel, 1'b0);
        check("underrun_set", underrun, 1'b1);
        repeat (20) @(negedge clk);
        check("underrun_sticky", underrun, 1'b1);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("underrun_cleared", underrun, 1'b0);

        // Line table: basic line, line advance, address wrap
        for (int v = 0; v < 3; v++) begin
            run_line(vecs[v].fs, vecs[v].a, vecs[v].aw, c_bpl * 8, 1'b0, 1'b1, f8);
            check("first_byte_pixels", f8, vecs[v].first);
        end

        // Mid-line restart with a read in flight
        run_line(1'b0, l4_a, l4_w, 100, 1'b0, 1'b0, f8);
        wait_ram_en("restart_inflight_seen");
        run_line(1'b0, l5_a, l5_w, c_bpl * 8, 1'b1, 1'b1, f8);
        check("restart_first_byte", f8, mem[l5_a]);

        // Reset mid-stream while a RAM response is returning
        run_line(1'b1, 15'h4000, 15'h7FF0, 50, 1'b0, 1'b0, f8);
        wait_ram_en("reset_inflight_seen");
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_ram_en", ram.ram_en, 1'b0);
        check("midrst_ram_addr", ram.ram_addr, 15'h0);
        check("midrst_pixel", pixel, 1'b0);
        check("midrst_underrun", underrun, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        q_a.delete();
        ones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pixel !== 1'b0) ones++;
        end
        reads = q_a.size();
        pix_en = 1'b0;
        check("postrst_pixels", ones, 0);
        check("postrst_reads", reads, 0);
        check("postrst_underrun", underrun, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/video_fetch.md
Name: video_fetch

Overview:
- Display-side consumer of the shared 32K x 8 video/CPU RAM's read-only port (port 2).
- Walks a 1bpp bitmap line by line and issues one-byte reads that have 1-cycle registered read latency.
- Buffers returned bytes in a small FIFO and serialises them MSB-first into a pixel stream, paced by the display timing generator's pix_en strobe.

Parameters:
- BASE_ADDR, 15'h4000, byte address of the first bitmap byte of the frame.
- BYTES_PER_LINE, 40, bytes fetched per scanline (320 pixels); range 1..255.
- FIFO_DEPTH, 4, byte FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  single clock; also drives RAM port 2 (clk2).
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  1-cycle pulse at the start of a frame.
- line_start  in  1  1-cycle pulse at the start of each visible scanline.
- pix_en  in  1  consume one pixel this cycle.
- ram_en  out  1  read strobe to RAM en2; registered.
- ram_addr  out  15  read address to RAM addr2; registered.
- ram_data  in  8  RAM dout2; valid the cycle after ram_en was sampled.
- pixel  out  1  current pixel; registered; updates only on pix_en.
- underrun  out  1  sticky flag: a pixel was needed but the FIFO was empty.

Behaviour:
- Reset values:
  - ram_en=0, ram_addr=0, pixel=0, underrun=0.
  - FIFO empty, shifter bit count 0, line inactive, line_base=BASE_ADDR, first_line=1.
- Frame start (frame_start):
  - line_base<=BASE_ADDR, first_line<=1, underrun<=0.
  - If asserted in the same cycle as line_start, frame_start is applied first, then the line_start is processed as the first line of the frame.
- Line start (line_start):
  - Flush the FIFO and clear the shifter.
  - Mark any in-flight read as discard: its returning ram_data is not written to the FIFO.
  - issued<=0, popped<=0, line active.
  - If first_line: keep line_base and clear first_line. Otherwise: line_base<=line_base+BYTES_PER_LINE, modulo 2^15 (wraps 7FFF->0000).
- Fetch: in any cycle where line active, issued<BYTES_PER_LINE, count+inflight<FIFO_DEPTH and no line_start:
  - next ram_en=1, ram_addr=line_base+issued (mod 2^15);
  - issued increments; inflight set.
  - Otherwise ram_en=0; ram_addr holds.
- Return: the cycle after ram_en was high, ram_data is pushed into the FIFO unless marked discard; inflight clears.
- Capacity: FIFO never overflows by construction. At most one read is in flight.
- Latency: line_start sampled at edge E0 → ram_en high after E1 → first byte in FIFO after E3. pix_en from the cycle after E3 never underruns at a sustained 1 pixel/cycle.
- Pixel shift, on pix_en:
  - Shifter bit count > 0: pixel<=sh[7], sh<<=1, count-1.
  - Else, FIFO non-empty: pop byte b; pixel<=b[7], sh<=b<<1, count<=7, popped+1.
  - Else, popped<BYTES_PER_LINE and line active: pixel<=0, underrun<=1.
  - Else (past end of line or no line active): pixel<=0 (border), no underrun.
- Without pix_en: pixel holds its value.
- pix_en in the same cycle as line_start: the flush wins; pixel<=0.
- Reset asserted mid-line: immediate return to reset values; the next RAM response is ignored because line is inactive.

Optional Feature:
- Macro: VIDEO_FETCH_DOUBLE_SCAN_EN.
- Defined: line_base advances only on every second non-first line_start, so each bitmap line is shown on two consecutive scanlines. A toggle (reset 0, cleared by frame_start) gates the advance.
- Undefined: line_base advances on every non-first line_start.

Decomposition:
- Package video_pkg holds:
  - VRAM_AW=15 and VRAM_DW=8;
  - the default BASE_ADDR and BYTES_PER_LINE constants;
  - typedef vaddr_t (15-bit) and vbyte_t (8-bit).
- One sub-module, byte_fifo: synchronous FIFO_DEPTH x 8 FIFO.
  - Ports: push, pop, flush, count, empty.
  - Asynchronous active-high reset.
  - Flush has priority over push/pop.

Test Plan:
- Reset: assert reset mid-stream → ram_en=0, ram_addr=0, pixel=0, underrun=0 immediately; no FIFO push on the following RAM response.
- Basic line: BASE=4000h, RAM[4000h]=A5h; frame_start+line_start, pix_en continuous from E3+1 → first ram_addr=4000h, pixels 1,0,1,0,0,1,0,1, exactly 40 reads (4000h..4027h), underrun=0.
- Line advance: three line_starts → first fetch addresses 4000h, 4028h, 4050h.
  - With VIDEO_FETCH_DOUBLE_SCAN_EN defined: 4000h, 4000h, 4028h.
- Wrap: BASE=7FF0h, second line → addresses 0018h onward after 7FF0h..7FFFh,0000h..0017h on the first line.
- Underrun: pix_en asserted the cycle right after line_start → pixel=0, underrun=1; flag stays set until the next frame_start, then 0.
- Mid-line restart: after 100 pixels, pulse line_start while a read is in flight → the in-flight byte is discarded, the FIFO is empty, and the first pixel after restart is the MSB of RAM[next line_base].
